// File: rtl/imem_sync_loader_if.sv
// rtl/imem_sync_loader_if.sv - fetch and program-load bus between the IF stage and the instruction memory
interface imem_sync_loader_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 9
);
   logic [ADDR_WIDTH-1:0] pc_addr;
   logic                  rd_en;
   logic                  flush;
   logic [31:0]           inst;
   logic                  inst_valid;
   logic                  fault;
   logic                  load_start;
   logic                  load_valid;
   logic [31:0]           load_data;
   logic                  load_last;
   logic                  load_ready;
   logic                  load_busy;
   logic [CNT_WIDTH-1:0]  load_count;

   modport master (
      output pc_addr, rd_en, flush, load_start, load_valid, load_data, load_last,
      input  inst, inst_valid, fault, load_ready, load_busy, load_count
   );

   modport slave (
      input  pc_addr, rd_en, flush, load_start, load_valid, load_data, load_last,
      output inst, inst_valid, fault, load_ready, load_busy, load_count
   );
endinterface

// File: rtl/imem_sync_loader.sv
// rtl/imem_sync_loader.sv - run-time loadable instruction memory with one-cycle registered fetch
module imem_sync_loader #(
   parameter int          DEPTH      = 256,
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] NOP_INST   = 32'h00000013
) (
   input  logic                clk,
   input  logic                rst_n,
   imem_sync_loader_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;

   logic [1:0]            state;
   logic [CNT_W-1:0]      load_count;
   logic [31:0]           mem [DEPTH];
   logic [31:0]           inst;
   logic                  inst_valid;
   logic                  fault;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  unloaded;
   logic                  accept;
   logic                  final_word;

   assign word_idx     = bus.pc_addr >> 2;
   assign misaligned   = bus.pc_addr[1:0] != 2'b00;
   assign out_of_range = word_idx >= ADDR_WIDTH'(DEPTH);
   // load_count bounds the readable region, so stale array contents never leak out
   assign unloaded     = word_idx >= ADDR_WIDTH'(load_count);

   assign accept     = (state == S_LOAD) && bus.load_valid;
   assign final_word = bus.load_last || (load_count == CNT_W'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         load_count <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (accept) begin
                  load_count <= load_count + 1'b1;
                  if (final_word)
                     state <= S_READY;
               end
            end
            default: begin
               if (bus.load_start) begin
                  state      <= S_LOAD;
                  load_count <= '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[load_count[IDX_W-1:0]] <= bus.load_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst       <= NOP_INST;
         inst_valid <= 1'b0;
         fault      <= 1'b0;
      end else if (state == S_LOAD || bus.flush) begin
         inst       <= NOP_INST;
         inst_valid <= 1'b0;
         fault      <= 1'b0;
      end else if (bus.rd_en) begin
         inst_valid <= 1'b1;
         if (misaligned || out_of_range) begin
            inst  <= NOP_INST;
            fault <= 1'b1;
         end else if (unloaded) begin
            inst  <= NOP_INST;
            fault <= 1'b0;
         end else begin
            inst  <= mem[word_idx[IDX_W-1:0]];
            fault <= 1'b0;
         end
      end
   end

   assign bus.inst       = inst;
   assign bus.inst_valid = inst_valid;
   assign bus.fault      = fault;
   assign bus.load_ready = (state == S_LOAD);
   assign bus.load_busy  = (state == S_LOAD);
   assign bus.load_count = load_count;
endmodule

// File: tb/tb_imem_sync_loader.sv
// tb/tb_imem_sync_loader.sv - directed and randomized checks of imem_sync_loader against a behavioural model
module tb_imem_sync_loader;
   localparam int          DEPTH = 8;
   localparam int          AW    = 32;
   localparam int          CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_sync_loader_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   imem_sync_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .NOP_INST(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // reference model: program image, number of valid words, whether a load is in progress
   logic [31:0] m_mem [DEPTH];
   int          m_count = 0;
   bit          m_loading = 0;
   logic [31:0] e_inst = NOP;
   logic        e_valid = 0;
   logic        e_fault = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".inst"},  bus.inst, e_inst);
      check({tag, ".valid"}, 32'(bus.inst_valid), 32'(e_valid));
      check({tag, ".fault"}, 32'(bus.fault), 32'(e_fault));
      check({tag, ".ready"}, 32'(bus.load_ready), 32'(m_loading));
      check({tag, ".busy"},  32'(bus.load_busy), 32'(m_loading));
      check({tag, ".count"}, 32'(bus.load_count), 32'(m_count));
   endtask

   // predict the effect of the coming edge from the current inputs, then clock and compare
   task automatic cycle(input string tag);
      longint unsigned byte_addr;
      longint unsigned word;
      if (m_loading) begin
         e_inst = NOP; e_valid = 0; e_fault = 0;
         if (bus.load_valid) begin
            m_mem[m_count] = bus.load_data;
            m_count++;
            if (bus.load_last || m_count == DEPTH) m_loading = 0;
         end
      end else begin
         if (bus.flush) begin
            e_inst = NOP; e_valid = 0; e_fault = 0;
         end else if (bus.rd_en) begin
            byte_addr = longint'(bus.pc_addr);
            word      = byte_addr / 4;
            e_valid   = 1;
            if (byte_addr % 4 != 0 || word >= DEPTH) begin
               e_inst = NOP; e_fault = 1;
            end else if (word >= longint'(m_count)) begin
               e_inst = NOP; e_fault = 0;
            end else begin
               e_inst = m_mem[word]; e_fault = 0;
            end
         end
         if (bus.load_start) begin
            m_loading = 1;
            m_count   = 0;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      bus.pc_addr = '0; bus.rd_en = 0; bus.flush = 0;
      bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
   endtask

   task automatic fetch(input logic [31:0] addr, input string tag);
      idle_inputs();
      bus.pc_addr = addr; bus.rd_en = 1;
      cycle(tag);
   endtask

   task automatic load_program(input logic [31:0] words[$]);
      idle_inputs();
      bus.load_start = 1;
      cycle("load_start");
      idle_inputs();
      foreach (words[i]) begin
         bus.load_valid = 1;
         bus.load_data  = words[i];
         bus.load_last  = (i == words.size() - 1);
         cycle("load_word");
      end
      idle_inputs();
   endtask

   initial begin
      logic [31:0] prog[$];
      int          budget;

      idle_inputs();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1;

      fetch(32'd0, "fetch_empty");
      check("fetch_empty.nop", bus.inst, 32'h00000013);

      prog = '{32'h00500113, 32'h00C00193, 32'hFF718393};
      load_program(prog);
      check("load3.count", 32'(bus.load_count), 32'd3);
      check("load3.busy", 32'(bus.load_busy), 32'd0);

      fetch(32'd0, "fetch_w0");
      check("fetch_w0.const", bus.inst, 32'h00500113);
      fetch(32'd4, "fetch_w1");
      fetch(32'd8, "fetch_w2");
      check("fetch_w2.const", bus.inst, 32'hFF718393);
      fetch(32'd12, "fetch_unloaded");
      fetch(32'd2, "fetch_misaligned");
      check("fetch_misaligned.fault", 32'(bus.fault), 32'd1);
      fetch(32'(4 * DEPTH), "fetch_oor");
      check("fetch_oor.fault", 32'(bus.fault), 32'd1);

      fetch(32'd4, "stall_pre");
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         bus.pc_addr = 32'(8 + 4 * i);
         bus.rd_en   = 0;
         cycle("stall");
         check("stall.hold", bus.inst, 32'h00C00193);
      end
      idle_inputs();
      bus.pc_addr = 32'd0; bus.rd_en = 1; bus.flush = 1;
      cycle("flush");
      check("flush.valid", 32'(bus.inst_valid), 32'd0);

      // overrun: DEPTH+2 words offered without load_last
      idle_inputs();
      bus.load_start = 1;
      cycle("ovf_start");
      for (int i = 0; i < DEPTH + 2; i++) begin
         idle_inputs();
         bus.load_valid = 1;
         bus.load_data  = $urandom;
         cycle("ovf_word");
      end
      check("ovf.count", 32'(bus.load_count), 32'(DEPTH));
      check("ovf.ready", 32'(bus.load_ready), 32'd0);
      for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i), "ovf_fetch");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle_inputs();
         bus.pc_addr    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4 * DEPTH + 8))
                                                      : 32'(4 * $urandom_range(0, DEPTH + 1));
         bus.rd_en      = $urandom_range(0, 3) != 0;
         bus.flush      = $urandom_range(0, 7) == 0;
         bus.load_start = $urandom_range(0, 24) == 0;
         bus.load_valid = $urandom_range(0, 2) != 0;
         bus.load_data  = $urandom;
         bus.load_last  = $urandom_range(0, 4) == 0;
         cycle("random");
      end

      // make sure any load left open by the random phase is closed
      idle_inputs();
      budget = 0;
      while (m_loading && budget < 2 * DEPTH) begin
         bus.load_valid = 1; bus.load_last = 1; bus.load_data = $urandom;
         cycle("drain");
         budget++;
      end
      check("drain.done", 32'(bus.load_busy), 32'd0);

      // reset asserted in the middle of a load
      idle_inputs();
      bus.load_start = 1;
      cycle("rst_load_start");
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         bus.load_valid = 1; bus.load_data = 32'h1000_0000 + 32'(i);
         cycle("rst_load_word");
      end
      idle_inputs();
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      m_loading = 0; m_count = 0;
      e_inst = NOP; e_valid = 0; e_fault = 0;
      check_all("mid_load_reset");
      @(negedge clk);
      rst_n = 1;
      fetch(32'd0, "post_reset_fetch");
      check("post_reset_fetch.nop", bus.inst, 32'h00000013);
      check("post_reset_fetch.fault", 32'(bus.fault), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_sync_loader.md
# imem_sync_loader

Parametrised, synchronous-read instruction memory for the pipelined RV32I core, sitting in the IF stage between the PC register and the IF/ID pipeline register. It replaces the fixed 32-entry combinational ROM with a configurable-depth array, one-cycle registered fetch with stall/flush control, alignment/range fault detection, and a streaming program-load port driven by a small FSM, so programs are loaded at run time instead of being hard-coded.

## Interface
- DEPTH, 256: number of 32-bit instruction words; any value ≥ 2.
- ADDR_WIDTH, 32: width of the byte address from the PC.
- NOP_INST, 32'h00000013: word returned on flush, fault, load, or unloaded location (addi x0,x0,0).

- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_addr  in  ADDR_WIDTH  byte address of instruction to fetch.
- rd_en  in  1  fetch enable; low = IF stall (outputs hold).
- flush  in  1  kill the fetched instruction (branch/jump taken).
- inst  out  32  fetched instruction, registered.
- inst_valid  out  1  inst is a real fetch result.
- fault  out  1  registered with inst: pc_addr misaligned or out of range.
- load_start  in  1  begin a program load at word 0.
- load_valid  in  1  load_data carries a word.
- load_data  in  32  instruction word to write.
- load_last  in  1  qualifies the final word of the program.
- load_ready  out  1  block accepts a load word this cycle.
- load_busy  out  1  FSM in LOAD.
- load_count  out  $clog2(DEPTH)+1  number of words loaded.

## Operation
- FSM states: IDLE (nothing loaded), LOAD, READY.
  - IDLE/READY + load_start → LOAD; load_count cleared to 0.
  - LOAD: load_ready = 1. On load_valid && load_ready: mem[load_count] ← load_data, load_count += 1.
  - LOAD → READY when the accepted word has load_last = 1, or when load_count reaches DEPTH (auto-terminate; later words are not accepted).
  - load_start while in LOAD is ignored.
- Fetch (any state except LOAD), word index = pc_addr >> 2:
  - Misaligned (pc_addr[1:0] ≠ 0) or index ≥ DEPTH: inst = NOP_INST, fault = 1, inst_valid = 1.
  - Index ≥ load_count (unloaded): inst = NOP_INST, fault = 0, inst_valid = 1.
  - Otherwise inst = mem[index], fault = 0, inst_valid = 1.
- During LOAD, fetches are suppressed: inst = NOP_INST, inst_valid = 0, fault = 0.
- Priority on each edge: LOAD state > flush > rd_en = 0 (hold) > normal fetch.
- Array contents are not reset. load_count resets to 0, so stale contents are never returned.

## Timing
- Reset values: inst = NOP_INST, inst_valid = 0, fault = 0, load_ready = 0, load_busy = 0, load_count = 0, state IDLE.
- Fetch latency: one cycle. pc_addr/rd_en sampled at edge N drive inst/fault/inst_valid after edge N.
- Stall: with rd_en = 0 and no flush, inst, fault and inst_valid hold their previous values.
- Flush: sampled high at edge N gives inst = NOP_INST, inst_valid = 0, fault = 0 after edge N, regardless of rd_en.
- Load handshake: a word is accepted on any edge where load_valid && load_ready. load_ready/load_busy rise one cycle after load_start is sampled, and fall on the edge that accepts the last word.
- Write-then-read: a word written at edge N is fetchable by a fetch sampled at edge N+1 or later. No fetch can occur in LOAD, so there is no same-cycle collision.
- Reset asserted mid-load: FSM returns to IDLE immediately and load_count = 0. The partial program is unreachable until reloaded.

## Test plan
- Reset then fetch pc_addr = 0 with no load → inst = 32'h00000013, inst_valid = 1, fault = 0 one cycle later.
- Load 3 words (00500113, 00C00193, FF718393; last on 3rd) → load_count = 3, state READY; fetch 0, 4, 8 → those words in order, 1-cycle latency; fetch 12 → NOP, fault = 0.
- Fetch pc_addr = 2 → NOP, fault = 1. Fetch pc_addr = 4*DEPTH → NOP, fault = 1.
- Fetch word 1, then rd_en = 0 for 3 cycles with changing pc_addr → inst holds 00C00193. Then flush = 1 with rd_en = 1 → inst = NOP, inst_valid = 0.
- Stream DEPTH+2 words with load_valid held high and no load_last → only DEPTH accepted, load_ready drops after word DEPTH-1, state READY.
- Assert rst_n = 0 after 2 of 5 load words → outputs at reset values, load_count = 0; a subsequent fetch of address 0 returns NOP.
